// File: rtl/cp0_int_ctrl_pkg.sv
// Shared definitions for the CP0 exception/interrupt sequencer:
// cp_oper encodings, CP0 register indices, exception codes and field positions.
package cp0_int_ctrl_pkg;

  // cp_oper encodings decoded in ID
  localparam logic [1:0] EXE_CP_NOP   = 2'd0;
  localparam logic [1:0] EXE_CP_STORE = 2'd1;
  localparam logic [1:0] EXE_CP0_ERET = 2'd2;

  // CP0 register indices (rd / addr_r)
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // Exception codes stored in CAUSE.ExcCode
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;

  // Field positions inside STATUS and CAUSE
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LSB  = 8;
  localparam int CAUSE_EXC_LSB  = 2;
  localparam int CAUSE_IP_LSB   = 8;

  // Sequencer states: RUN accepts events, REDIR covers the flushed ID bubble
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } cp0_state_e;

  // Event chosen by the arbiter in a given cycle
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_RI   = 2'd1,
    EV_ERET = 2'd2,
    EV_INT  = 2'd3
  } cp0_event_e;

  // Assemble the architectural STATUS word; unused bits read as zero
  function automatic logic [31:0] packStatus(input logic ie, input logic exl,
                                             input logic [7:0] im);
    logic [31:0] word;
    word = '0;
    word[STATUS_IE_BIT]            = ie;
    word[STATUS_EXL_BIT]           = exl;
    word[STATUS_IM_LSB +: 8]       = im;
    return word;
  endfunction

  // Assemble the architectural CAUSE word; unused bits read as zero
  function automatic logic [31:0] packCause(input logic [7:0] ip,
                                            input logic [4:0] excCode);
    logic [31:0] word;
    word = '0;
    word[CAUSE_EXC_LSB +: 5] = excCode;
    word[CAUSE_IP_LSB +: 8]  = ip;
    return word;
  endfunction

endpackage

// File: rtl/cp0_int_ctrl_irq_sync.sv
// Two-flop vector synchroniser for asynchronous level interrupt lines.
// It always samples, independent of any pipeline stall, so IP tracks irq with
// a fixed two-cycle latency.
module irq_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;

  // Shift the raw lines through two flops to settle metastability
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 exception and interrupt sequencer.
// Holds STATUS/CAUSE/EPC, arbitrates RI > ERET > INT > MTC0 one event per
// cycle, and emits a one-cycle redirect that the pipeline uses to flush ID.
import cp0_int_ctrl_pkg::*;

module cp0_int_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0010,
  parameter int          HOLDOFF    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               id_valid_i,
  input  logic               is_branch_id_i,
  input  logic               unrecognized_i,
  input  logic [1:0]         cp_oper_i,
  input  logic [31:0]        pc_id_i,
  input  logic [31:0]        pc_if_i,
  input  logic [4:0]         addr_w_i,
  input  logic [31:0]        data_w_i,
  input  logic [4:0]         addr_r_i,
  output logic [31:0]        data_r_o,
  output logic               jump_en_o,
  output logic [31:0]        jump_addr_o,
  output logic               exl_o
);

  localparam logic [2:0] HOLDOFF_INIT = 3'(HOLDOFF);

  // Architectural and sequencing state
  cp0_state_e         state_q,   state_d;
  logic               ie_q,      ie_d;
  logic               exl_q,     exl_d;
  logic [NUM_IRQ-1:0] im_q,      im_d;
  logic [4:0]         excCode_q, excCode_d;
  logic [31:0]        epc_q,     epc_d;
  logic [2:0]         holdoff_q, holdoff_d;

  logic [NUM_IRQ-1:0] ipSync;
  logic               eligible;
  logic               intRequest;
  logic               mtc0Write;
  cp0_event_e         eventSel;
  logic [7:0]         imWide;
  logic [7:0]         ipWide;

  irq_sync #(
    .WIDTH (NUM_IRQ)
  ) u_irq_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (irq_i),
    .q_o   (ipSync)
  );

  // Decide which single event, if any, the ID instruction triggers this cycle
  always_comb begin
    eligible   = en_i && !rst_i && id_valid_i && (state_q == ST_RUN);
    intRequest = (|(ipSync & im_q)) && ie_q && !exl_q && !is_branch_id_i &&
                 (holdoff_q == 3'd0);
    eventSel   = EV_NONE;
    if (eligible) begin
      if (unrecognized_i && !exl_q) begin
        eventSel = EV_RI;
      end else if (cp_oper_i == EXE_CP0_ERET) begin
        eventSel = EV_ERET;
      end else if (intRequest) begin
        eventSel = EV_INT;
      end
    end
    mtc0Write = eligible && (eventSel == EV_NONE) && (cp_oper_i == EXE_CP_STORE);
  end

  // Mealy redirect: pulse in the decision cycle, target zero when idle
  always_comb begin
    jump_en_o   = (eventSel != EV_NONE);
    jump_addr_o = '0;
    case (eventSel)
      EV_RI, EV_INT: jump_addr_o = EXC_VECTOR;
      EV_ERET:       jump_addr_o = epc_q;
      default:       jump_addr_o = '0;
    endcase
  end

  // Next-state for registers, holdoff counter and FSM
  always_comb begin
    state_d   = (eventSel != EV_NONE) ? ST_REDIR : ST_RUN;
    ie_d      = ie_q;
    exl_d     = exl_q;
    im_d      = im_q;
    excCode_d = excCode_q;
    epc_d     = epc_q;
    holdoff_d = (holdoff_q != 3'd0) ? (holdoff_q - 3'd1) : 3'd0;
    case (eventSel)
      EV_RI: begin
        epc_d     = pc_id_i;
        excCode_d = EXC_RI;
        exl_d     = 1'b1;
      end
      EV_ERET: begin
        exl_d     = 1'b0;
        holdoff_d = HOLDOFF_INIT;
      end
      EV_INT: begin
        epc_d     = pc_if_i;
        excCode_d = EXC_INT;
        exl_d     = 1'b1;
      end
      default: begin
        if (mtc0Write) begin
          case (addr_w_i)
            CP0_STATUS: begin
              ie_d      = data_w_i[STATUS_IE_BIT];
              exl_d     = data_w_i[STATUS_EXL_BIT];
              im_d      = data_w_i[STATUS_IM_LSB +: NUM_IRQ];
              holdoff_d = HOLDOFF_INIT;
            end
            CP0_EPC: epc_d = data_w_i;
            default: ;
          endcase
        end
      end
    endcase
  end

  // Register update; everything freezes while the stage is disabled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      im_q      <= '0;
      excCode_q <= EXC_INT;
      epc_q     <= '0;
      holdoff_q <= 3'd0;
    end else if (en_i) begin
      state_q   <= state_d;
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      im_q      <= im_d;
      excCode_q <= excCode_d;
      epc_q     <= epc_d;
      holdoff_q <= holdoff_d;
    end
  end

  // MFC0 read port over the current register contents
  always_comb begin
    imWide = '0;
    ipWide = '0;
    imWide[NUM_IRQ-1:0] = im_q;
    ipWide[NUM_IRQ-1:0] = ipSync;
    case (addr_r_i)
      CP0_STATUS: data_r_o = packStatus(ie_q, exl_q, imWide);
      CP0_CAUSE:  data_r_o = packCause(ipWide, excCode_q);
      CP0_EPC:    data_r_o = epc_q;
      default:    data_r_o = '0;
    endcase
  end

  assign exl_o = exl_q;

endmodule

// File: doc/cp0_int_ctrl.md
Name: cp0_int_ctrl

Overview:
Coprocessor-0 exception and interrupt sequencer for the MIPS 5-stage pipeline.
- Holds the STATUS, CAUSE and EPC registers.
- Synchronises the external interrupt lines and arbitrates between reserved-instruction exceptions, ERET and interrupts, one event at a time.
- Issues a one-cycle redirect (jump_en / jump_addr). The pipeline controller uses jump_en to flush ID.
- Sits beside ID and executes the cp_oper codes decoded there (MTC0, ERET). It also serves MFC0 reads.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..8).
- EXC_VECTOR, 32'h0000_0010, handler entry address.
- HOLDOFF, 2, cycles interrupts stay masked after ERET or a STATUS write (1..7).

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous reset, active-high
- en  in  1  stage enable; 0 freezes the block (debug/stall)
- irq  in  NUM_IRQ  asynchronous level interrupt requests
- id_valid  in  1  ID holds a valid instruction
- is_branch_id  in  1  ID instruction is a jump/branch
- unrecognized  in  1  ID instruction undecodable (from decoder)
- cp_oper  in  2  0 NOP, 1 MTC0 (EXE_CP_STORE), 2 ERET (EXE_CP0_ERET)
- pc_id  in  32  PC of the ID instruction
- pc_if  in  32  PC of the IF instruction
- addr_w  in  5  MTC0 destination register (rd)
- data_w  in  32  MTC0 write data (forwarded rt)
- addr_r  in  5  MFC0 source register
- data_r  out  32  MFC0 read data, combinational
- jump_en  out  1  redirect pulse
- jump_addr  out  32  redirect target; 0 when jump_en=0
- exl  out  1  STATUS.EXL (in handler)

Behaviour:
- STATUS (reg 12):
  - bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM.
  - All other bits read as 0.
- CAUSE (reg 13):
  - bits[8+NUM_IRQ-1:8] IP = synchronised irq (read-only).
  - bits[6:2] ExcCode, writable by hardware only.
  - All other bits read as 0.
- EPC (reg 14): 32 bits, read/write.
- Reads: any other addr_r reads as 0.
- irq path: 2-flop synchroniser, so irq→IP latency is 2 cycles. The synchroniser samples even when en=0.
- Event is "eligible" only when all of these hold: en=1, id_valid=1, holdoff counter=0 (interrupts only), state RUN.
- Priority, at most one event per cycle:
  1. RI: unrecognized=1 and EXL=0.
     - jump_en=1, jump_addr=EXC_VECTOR.
     - At the edge: EPC<=pc_id, ExcCode<=10, EXL<=1.
  2. ERET: cp_oper=2.
     - jump_en=1, jump_addr=EPC (value before this edge).
     - At the edge: EXL<=0, holdoff<=HOLDOFF.
  3. INT: |(IP&IM), IE=1, EXL=0, is_branch_id=0, holdoff=0.
     - jump_en=1, jump_addr=EXC_VECTOR.
     - At the edge: EPC<=pc_if (the ID instruction completes; the IF instruction is squashed), ExcCode<=0, EXL<=1.
  4. MTC0: cp_oper=1 and no higher event this cycle.
     - Write the addressed register at the edge. Writes to CAUSE and unknown addresses are ignored.
     - A STATUS write also loads holdoff<=HOLDOFF.
- jump_en is Mealy (same cycle as the decision) and asserted exactly one cycle per event. The FSM then enters REDIR for 1 cycle, in which no event is accepted (the flushed ID slot is a bubble). REDIR→RUN unconditionally.
- States: RUN, REDIR.
- holdoff counter decrements by 1 per en cycle and saturates at 0.
- unrecognized while EXL=1: ignored (no nested exception); the instruction proceeds as a NOP.
- en=0:
  - All registers, FSM and counter hold.
  - jump_en=0.
- Reset, including mid-REDIR:
  - STATUS=0, ExcCode=0, EPC=0, holdoff=0, synchroniser=0, state=RUN.
  - jump_en=0, jump_addr=0, exl=0, data_r reflects the reset registers.

Decomposition:
- mips_define.vh holds:
  - cp_oper encodings (EXE_CP_NOP/STORE/ERET);
  - CP0 register indices (CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14);
  - ExcCodes (EXC_INT=0, EXC_RI=10);
  - STATUS bit positions.
- Sub-module irq_sync: parameterised 2-flop vector synchroniser with synchronous reset.

Test Plan:
- Reset, then MTC0 STATUS=32'h0000_0301, then read reg 12 → data_r=32'h0000_0301; exl=0; 2-cycle holdoff observed.
- irq[0]=1 with IM0=1, IE=1, pc_if=0x40, id_valid=1:
  - jump_en pulses 2 cycles after irq, once the holdoff has expired (irq sampled after HOLDOFF), with jump_addr=0x10.
  - Then EPC=0x40, ExcCode=0, exl=1.
  - Next cycle jump_en=0 (REDIR).
- ERET in the handler with EPC=0x40 → jump_en=1, jump_addr=0x40, exl=0. irq still high → interrupt retaken exactly after the 2-cycle holdoff plus REDIR.
- unrecognized=1 and irq pending in the same cycle, EXL=0, pc_id=0x20 → RI wins: EPC=0x20, ExcCode=10, single jump_en pulse.
- irq pending with is_branch_id=1 → no jump_en. The interrupt is taken on the first cycle with is_branch_id=0. With en=0 the interrupt waits and no register changes.
- rst asserted during REDIR → next cycle all outputs are at reset values, and a pending irq is not taken (IE=0).
